// File: rtl/tdm_slot_bridge.sv
// ST-bus TDM slot to STM serial bridge: one timeslot byte per frame is captured into a
// ping-pong rx bank and replayed from a matching tx bank; the STM drains/refills the idle pair.
module tdm_slot_bridge #(
  parameter int CHANNELS   = 32,
  parameter int BITS       = 8,
  parameter int C4_PER_BIT = 2,
  parameter int DEPTH      = 16,
  parameter int SYNC       = 2
) (
  input  logic                        clk50,
  input  logic                        reset_rg_n,
  input  logic                        c4,
  input  logic                        f0,
  input  logic [$clog2(CHANNELS)-1:0] slot_sel,
  input  logic                        data_from_dt,
  output logic                        data_to_dt,
  input  logic                        clk_from_stm,
  input  logic                        data_from_stm,
  output logic                        data_to_stm,
  output logic                        cpu_int,
  output logic                        overrun
);

  localparam int FRAME_LEN = CHANNELS * BITS * C4_PER_BIT;
  localparam int SLOT_LEN  = BITS * C4_PER_BIT;
  localparam int BC_W      = $clog2(FRAME_LEN);
  localparam int SEL_W     = $clog2(CHANNELS);
  localparam int BIT_W     = $clog2(BITS);
  localparam int WP_W      = $clog2(DEPTH);
  localparam int SP_W      = $clog2(DEPTH * BITS);

  // Input synchronisers; data lines share the clock lines' depth so they stay aligned.
  logic [SYNC-1:0] c4_sync_q;
  logic [SYNC-1:0] f0_sync_q;
  logic [SYNC-1:0] dt_sync_q;
  logic [SYNC-1:0] sck_sync_q;
  logic [SYNC-1:0] sdi_sync_q;
  logic            c4_last_q;
  logic            sck_last_q;

  always_ff @(posedge clk50 or negedge reset_rg_n) begin
    if (!reset_rg_n) begin
      c4_sync_q  <= '0;
      f0_sync_q  <= '1;
      dt_sync_q  <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      c4_last_q  <= 1'b0;
      sck_last_q <= 1'b0;
    end else begin
      c4_sync_q  <= {c4_sync_q[SYNC-2:0], c4};
      f0_sync_q  <= {f0_sync_q[SYNC-2:0], f0};
      dt_sync_q  <= {dt_sync_q[SYNC-2:0], data_from_dt};
      sck_sync_q <= {sck_sync_q[SYNC-2:0], clk_from_stm};
      sdi_sync_q <= {sdi_sync_q[SYNC-2:0], data_from_stm};
      c4_last_q  <= c4_sync_q[SYNC-1];
      sck_last_q <= sck_sync_q[SYNC-1];
    end
  end

  logic c4_rise;
  logic f0_low;
  logic dt_bit;
  logic sck_rise;
  logic sck_fall;
  logic sdi_bit;

  assign c4_rise  = c4_sync_q[SYNC-1] & ~c4_last_q;
  assign f0_low   = ~f0_sync_q[SYNC-1];
  assign dt_bit   = dt_sync_q[SYNC-1];
  assign sck_rise = sck_sync_q[SYNC-1] & ~sck_last_q;
  assign sck_fall = ~sck_sync_q[SYNC-1] & sck_last_q;
  assign sdi_bit  = sdi_sync_q[SYNC-1];

  logic [BC_W-1:0]  bc_q, bc_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [WP_W-1:0]  wp_q, wp_d;
  logic             act_q, act_d;
  logic             swap_q, swap_d;
  logic             cpu_int_q, cpu_int_d;
  logic             clr_q, clr_d;
  logic             overrun_q, overrun_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [BITS-1:0]  stm_sh_q, stm_sh_d;
  logic             dtd_q, dtd_d;
  logic             dts_q, dts_d;

  // Bank index is act_q for the TDM side and ~act_q for the STM side.
  logic [BITS-1:0] rx_mem_q [2][DEPTH];
  logic [BITS-1:0] tx_mem_q [2][DEPTH];

  logic            rx_we;
  logic            rx_wbank;
  logic [WP_W-1:0] rx_widx;
  logic [BITS-1:0] rx_wdata;
  logic            tx_we;
  logic            tx_wbank;
  logic [WP_W-1:0] tx_widx;
  logic [BITS-1:0] tx_wdata;

  int unsigned      bc_i;
  int unsigned      phase_i;
  int unsigned      sp_i;
  logic             in_slot;
  logic [BIT_W-1:0] tdm_idx;
  logic [WP_W-1:0]  sp_byte;
  logic [BIT_W-1:0] sp_idx;
  logic             rdy;

  always_comb begin
    bc_d      = bc_q;
    sel_d     = sel_q;
    rx_sh_d   = rx_sh_q;
    wp_d      = wp_q;
    act_d     = act_q;
    swap_d    = 1'b0;
    cpu_int_d = cpu_int_q;
    clr_d     = 1'b0;
    overrun_d = overrun_q;
    sp_d      = sp_q;
    stm_sh_d  = stm_sh_q;
    dtd_d     = dtd_q;
    dts_d     = dts_q;
    rx_we     = 1'b0;
    rx_wbank  = act_q;
    rx_widx   = wp_q;
    rx_wdata  = rx_sh_q;
    tx_we     = 1'b0;
    tx_wbank  = ~act_q;
    tx_widx   = '0;
    tx_wdata  = stm_sh_q;
    bc_i      = 0;
    phase_i   = 0;
    sp_i      = 0;
    in_slot   = 1'b0;
    tdm_idx   = '0;
    sp_byte   = '0;
    sp_idx    = '0;
    rdy       = ~act_q;

    // Swap is resolved before either serial side so both see the new bank roles this cycle.
    if (swap_q) begin
      act_d     = ~act_q;
      wp_d      = '0;
      sp_d      = '0;
      cpu_int_d = 1'b1;
      overrun_d = overrun_q | cpu_int_q;
    end else if (clr_q) begin
      cpu_int_d = 1'b0;
    end

    if (c4_rise) begin
      if (f0_low) begin
        bc_d    = '0;
        sel_d   = slot_sel;
        rx_sh_d = '0;
      end else if (bc_q == BC_W'(FRAME_LEN - 1)) begin
        bc_d = '0;
      end else begin
        bc_d = bc_q + BC_W'(1);
      end
      bc_i    = 32'(bc_d);
      in_slot = (bc_i / SLOT_LEN) == 32'(sel_d);
      phase_i = bc_i % C4_PER_BIT;
      tdm_idx = BIT_W'((BITS - 1) - (bc_i / C4_PER_BIT) % BITS);
      if (!in_slot) begin
        dtd_d = 1'b1;
      end else if (phase_i == 0) begin
        dtd_d = tx_mem_q[act_d][wp_d][tdm_idx];
      end
      // Sample mid-bit; index 0 is the last bit of the byte.
      if (in_slot && phase_i == C4_PER_BIT / 2) begin
        rx_sh_d = {rx_sh_q[BITS-2:0], dt_bit};
        if (tdm_idx == '0) begin
          rx_we    = 1'b1;
          rx_wbank = act_d;
          rx_widx  = wp_d;
          rx_wdata = rx_sh_d;
          if (wp_d == WP_W'(DEPTH - 1)) begin
            wp_d   = '0;
            swap_d = 1'b1;
          end else begin
            wp_d = wp_d + WP_W'(1);
          end
        end
      end
    end

    rdy     = ~act_d;
    sp_i    = 32'(sp_d);
    sp_byte = WP_W'(sp_i / BITS);
    sp_idx  = BIT_W'((BITS - 1) - sp_i % BITS);
    if (sck_rise) begin
      dts_d = rx_mem_q[rdy][sp_byte][sp_idx];
    end
    if (sck_fall) begin
      stm_sh_d = {stm_sh_q[BITS-2:0], sdi_bit};
      if (sp_idx == '0) begin
        tx_we    = 1'b1;
        tx_wbank = rdy;
        tx_widx  = sp_byte;
        tx_wdata = stm_sh_d;
      end
      if (sp_d == SP_W'(DEPTH * BITS - 1)) begin
        sp_d  = '0;
        clr_d = 1'b1;
      end else begin
        sp_d = sp_d + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset_rg_n) begin
    if (!reset_rg_n) begin
      bc_q      <= '0;
      sel_q     <= '0;
      rx_sh_q   <= '0;
      wp_q      <= '0;
      act_q     <= 1'b0;
      swap_q    <= 1'b0;
      cpu_int_q <= 1'b0;
      clr_q     <= 1'b0;
      overrun_q <= 1'b0;
      sp_q      <= '0;
      stm_sh_q  <= '0;
      dtd_q     <= 1'b1;
      dts_q     <= 1'b0;
    end else begin
      bc_q      <= bc_d;
      sel_q     <= sel_d;
      rx_sh_q   <= rx_sh_d;
      wp_q      <= wp_d;
      act_q     <= act_d;
      swap_q    <= swap_d;
      cpu_int_q <= cpu_int_d;
      clr_q     <= clr_d;
      overrun_q <= overrun_d;
      sp_q      <= sp_d;
      stm_sh_q  <= stm_sh_d;
      dtd_q     <= dtd_d;
      dts_q     <= dts_d;
    end
  end

  always_ff @(posedge clk50 or negedge reset_rg_n) begin
    if (!reset_rg_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          rx_mem_q[b][i] <= '0;
          tx_mem_q[b][i] <= '1;
        end
      end
    end else begin
      if (rx_we) begin
        rx_mem_q[rx_wbank][rx_widx] <= rx_wdata;
      end
      if (tx_we) begin
        tx_mem_q[tx_wbank][tx_widx] <= tx_wdata;
      end
    end
  end

  assign data_to_dt  = dtd_q;
  assign data_to_stm = dts_q;
  assign cpu_int     = cpu_int_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_tdm_slot_bridge.sv
// Directed bench for tdm_slot_bridge: bank fill, STM readout/writeback, overrun,
// mid-slot frame pulse and reset during readout. Four channels keep frames short.
module tb_tdm_slot_bridge;

  localparam int CHANNELS = 4;
  localparam int BITS     = 8;
  localparam int CPB      = 2;
  localparam int DEPTH    = 16;
  localparam int FRAME    = CHANNELS * BITS * CPB;
  localparam int SLOT     = 3;

  logic       clk50         = 1'b0;
  logic       reset_rg_n    = 1'b0;
  logic       c4            = 1'b0;
  logic       f0            = 1'b1;
  logic [1:0] slot_sel      = 2'd3;
  logic       data_from_dt  = 1'b1;
  logic       data_to_dt;
  logic       clk_from_stm  = 1'b0;
  logic       data_from_stm = 1'b0;
  logic       data_to_stm;
  logic       cpu_int;
  logic       overrun;

  int         n_checks    = 0;
  int         n_fail      = 0;
  int         int_rises   = 0;
  logic       cpu_int_prev = 1'b0;
  logic       int_at_last  = 1'b0;
  logic [7:0] rd_bytes [DEPTH];

  tdm_slot_bridge #(
    .CHANNELS  (CHANNELS),
    .BITS      (BITS),
    .C4_PER_BIT(CPB),
    .DEPTH     (DEPTH),
    .SYNC      (2)
  ) dut (
    .clk50        (clk50),
    .reset_rg_n   (reset_rg_n),
    .c4           (c4),
    .f0           (f0),
    .slot_sel     (slot_sel),
    .data_from_dt (data_from_dt),
    .data_to_dt   (data_to_dt),
    .clk_from_stm (clk_from_stm),
    .data_from_stm(data_from_stm),
    .data_to_stm  (data_to_stm),
    .cpu_int      (cpu_int),
    .overrun      (overrun)
  );

  // clock / reset
  always #10 clk50 = ~clk50;

  always @(negedge clk50) begin
    if (cpu_int === 1'b1 && cpu_int_prev === 1'b0) int_rises++;
    cpu_int_prev = cpu_int;
  end

  // driver: one frame of n_rises c4 periods; data_to_dt checked after every rise
  task automatic send_frame(input logic [7:0] rx_byte, input logic [7:0] tx_exp,
                            input int n_rises, input int fno);
    int         errs;
    int         slot;
    int         bitn;
    logic       exp_dt;
    logic [7:0] rb;
    logic [7:0] tb;
    errs = 0;
    rb   = rx_byte;
    tb   = tx_exp;
    for (int k = 0; k < n_rises; k++) begin
      slot = k / (BITS * CPB);
      bitn = (k / CPB) % BITS;
      f0   = (k == 0) ? 1'b0 : 1'b1;
      data_from_dt = (slot == SLOT) ? rb[7-bitn] : 1'($urandom_range(0, 1));
      #20 c4 = 1'b1;
      #80 c4 = 1'b0;
      #60;
      exp_dt = (slot == SLOT) ? tb[7-bitn] : 1'b1;
      if (data_to_dt !== exp_dt) errs++;
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL data_to_dt frame %0d: %0d wrong bits, required 0", fno, errs);
    end
  endtask

  // driver: nbits STM clocks, writing wbyte repeatedly, collecting data_to_stm
  task automatic stm_read(input int nbits, input logic [7:0] wbyte);
    logic [7:0] wb;
    wb = wbyte;
    for (int i = 0; i < DEPTH; i++) rd_bytes[i] = 8'h00;
    for (int j = 0; j < nbits; j++) begin
      clk_from_stm = 1'b1;
      #100 data_from_stm = wb[7-(j%8)];
      #20;
      rd_bytes[j/8][7-(j%8)] = data_to_stm;
      if (j == nbits - 1) int_at_last = cpu_int;
      clk_from_stm = 1'b0;
      #120;
    end
  endtask

  task automatic test_reset();
    reset_rg_n = 1'b0;
    repeat (4) @(negedge clk50);
    reset_rg_n = 1'b1;
    repeat (4) @(negedge clk50);
    n_checks++;
    if (data_to_dt !== 1'b1) begin n_fail++; $display("FAIL reset data_to_dt: got %b want 1", data_to_dt); end
    n_checks++;
    if (data_to_stm !== 1'b0) begin n_fail++; $display("FAIL reset data_to_stm: got %b want 0", data_to_stm); end
    n_checks++;
    if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL reset cpu_int: got %b want 0", cpu_int); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b want 0", overrun); end
  endtask

  task automatic test_fill();
    @(negedge clk50);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'hA5 + 8'(i), 8'hFF, FRAME, i);
      if (i == DEPTH - 2) begin
        n_checks++;
        if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL fill early cpu_int: got %b want 0", cpu_int); end
      end
    end
    n_checks++;
    if (cpu_int !== 1'b1) begin n_fail++; $display("FAIL fill cpu_int: got %b want 1", cpu_int); end
    n_checks++;
    if (int_rises !== 1) begin n_fail++; $display("FAIL fill int_rises: got %0d want 1", int_rises); end
  endtask

  task automatic test_readout();
    @(negedge clk50);
    stm_read(DEPTH * BITS, 8'h3C);
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_bytes[i] !== 8'hA5 + 8'(i)) begin
        n_fail++;
        $display("FAIL readout byte %0d: got %h want %h", i, rd_bytes[i], 8'hA5 + 8'(i));
      end
    end
    n_checks++;
    if (int_at_last !== 1'b1) begin n_fail++; $display("FAIL readout cpu_int before last fall: got %b want 1", int_at_last); end
    n_checks++;
    if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL readout cpu_int after last fall: got %b want 0", cpu_int); end
  endtask

  task automatic test_second_fill();
    @(negedge clk50);
    for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 8'hFF, FRAME, 100 + i);
    n_checks++;
    if (cpu_int !== 1'b1) begin n_fail++; $display("FAIL fill2 cpu_int: got %b want 1", cpu_int); end
    n_checks++;
    if (int_rises !== 2) begin n_fail++; $display("FAIL fill2 int_rises: got %0d want 2", int_rises); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL fill2 overrun: got %b want 0", overrun); end
  endtask

  task automatic test_tx_overrun();
    @(negedge clk50);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'hC1 + 8'(i), 8'h3C, FRAME, 200 + i);
      if (i == DEPTH - 2) begin
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun early: got %b want 0", overrun); end
      end
    end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun set: got %b want 1", overrun); end
    n_checks++;
    if (cpu_int !== 1'b1) begin n_fail++; $display("FAIL overrun cpu_int: got %b want 1", cpu_int); end
    n_checks++;
    if (int_rises !== 2) begin n_fail++; $display("FAIL overrun int_rises: got %0d want 2", int_rises); end
  endtask

  task automatic test_reset_mid_readout();
    @(negedge clk50);
    stm_read(24, 8'h00);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_bytes[i] !== 8'hC1 + 8'(i)) begin
        n_fail++;
        $display("FAIL newest bank byte %0d: got %h want %h", i, rd_bytes[i], 8'hC1 + 8'(i));
      end
    end
    reset_rg_n = 1'b0;
    repeat (3) @(negedge clk50);
    n_checks++;
    if (data_to_dt !== 1'b1) begin n_fail++; $display("FAIL midreset data_to_dt: got %b want 1", data_to_dt); end
    n_checks++;
    if (data_to_stm !== 1'b0) begin n_fail++; $display("FAIL midreset data_to_stm: got %b want 0", data_to_stm); end
    n_checks++;
    if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL midreset cpu_int: got %b want 0", cpu_int); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset overrun: got %b want 0", overrun); end
    reset_rg_n = 1'b1;
    repeat (3) @(negedge clk50);
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 8'hFF, FRAME, 300 + i);
    n_checks++;
    if (int_rises !== 3) begin n_fail++; $display("FAIL post-reset int_rises: got %0d want 3", int_rises); end
    stm_read(DEPTH * BITS, 8'hFF);
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_bytes[i] !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL post-reset byte %0d: got %h want %h", i, rd_bytes[i], 8'h10 + 8'(i));
      end
    end
    n_checks++;
    if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL post-reset cpu_int after read: got %b want 0", cpu_int); end
  endtask

  task automatic test_f0_mid_slot();
    @(negedge clk50);
    send_frame(8'h55, 8'hFF, FRAME, 400);
    // frame cut after four bits of slot 3; the next rise carries f0
    send_frame(8'h99, 8'hFF, 56, 401);
    for (int i = 0; i < DEPTH - 1; i++) begin
      send_frame(8'h60 + 8'(i), 8'hFF, FRAME, 402 + i);
      if (i == DEPTH - 3) begin
        n_checks++;
        if (cpu_int !== 1'b0) begin n_fail++; $display("FAIL cut cpu_int early: got %b want 0", cpu_int); end
      end
    end
    n_checks++;
    if (cpu_int !== 1'b1) begin n_fail++; $display("FAIL cut cpu_int: got %b want 1", cpu_int); end
    stm_read(16, 8'hFF);
    n_checks++;
    if (rd_bytes[0] !== 8'h55) begin n_fail++; $display("FAIL cut byte 0: got %h want 55", rd_bytes[0]); end
    n_checks++;
    if (rd_bytes[1] !== 8'h60) begin n_fail++; $display("FAIL cut byte 1: got %h want 60", rd_bytes[1]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_readout();
    test_second_fill();
    test_tx_overrun();
    test_reset_mid_readout();
    test_f0_mid_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
